prescaler_nch: RTL and testbench

PRESCALER_NCH -- requirements
Module: prescaler_nch

---
 rtl/prescaler_pkg.sv | 20 ++
 rtl/prescaler_ch.sv | 87 ++++++++
 rtl/prescaler_nch.sv | 44 ++++
 tb/tb_prescaler_nch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared definitions for the multi-channel prescaler: mode encodings,
// the per-select limit function and the parameter legality check.
package prescaler_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // The fastest select must still leave a limit of at least 1 (2**1-1).
  function automatic bit params_legal(input int nb_sel, input int nb_counter,
                                      input int base_shift);
    return (nb_counter - base_shift - ((1 << nb_sel) - 1)) >= 1;
  endfunction

  // k=0 is the slowest speed; each step up halves the period.
  function automatic logic [63:0] limit_of(input int nb_counter, input int base_shift,
                                           input int k);
    return (64'd1 << (nb_counter - base_shift - k)) - 64'd1;
  endfunction

endpackage

// File: rtl/prescaler_ch.sv
// One prescaler channel: selectable-speed counter with periodic or
// one-shot tick generation, start/resync strobe and select-change restart.
module prescaler_ch
  import prescaler_pkg::*;
#(
  parameter int NB_SEL     = 2,
  parameter int NB_COUNTER = 32,
  parameter int BASE_SHIFT = 10
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  enable,
  input  logic [NB_SEL-1:0]     sel,
  input  logic                  mode,
  input  logic                  start,
  output logic                  tick,
  output logic                  active,
  output logic [NB_COUNTER-1:0] count
);

  logic [NB_SEL-1:0]     sel_q;
  logic                  mode_q;
  logic                  init_done;
  logic [NB_COUNTER-1:0] limit;
  logic [NB_COUNTER-1:0] count_n;
  logic                  active_n;
  logic                  tick_n;
  logic                  sel_chg;
  logic                  mode_chg;

  always_comb limit = NB_COUNTER'(limit_of(NB_COUNTER, BASE_SHIFT, int'(sel_q)));

  assign sel_chg  = (sel != sel_q);
  assign mode_chg = (mode != mode_q);

  // Priority: first edge after reset, mode switch, select change, start, count.
  always_comb begin
    count_n  = count;
    active_n = active;
    tick_n   = 1'b0;
    if (!init_done) begin
      active_n = (mode == MODE_PERIODIC);
      if (sel_chg) count_n = '0;
    end else if (mode_chg) begin
      if (mode == MODE_ONESHOT) begin
        active_n = 1'b0;
        count_n  = '0;
      end else begin
        active_n = 1'b1;
      end
      if (sel_chg) count_n = '0;
    end else if (sel_chg) begin
      count_n = '0;
      if (enable && start) active_n = 1'b1;
    end else if (enable && start) begin
      count_n  = '0;
      active_n = 1'b1;
    end else if (enable && active) begin
      if (count >= limit) begin
        count_n = '0;
        tick_n  = 1'b1;
        if (mode_q == MODE_ONESHOT) active_n = 1'b0;
      end else begin
        count_n = count + NB_COUNTER'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      count     <= '0;
      tick      <= 1'b0;
      active    <= 1'b0;
      sel_q     <= '0;
      mode_q    <= MODE_PERIODIC;
      init_done <= 1'b0;
    end else begin
      count     <= count_n;
      tick      <= tick_n;
      active    <= active_n;
      sel_q     <= sel;
      mode_q    <= mode;
      init_done <= 1'b1;
    end
  end

endmodule

// File: rtl/prescaler_nch.sv
// NB_CH independent prescaler channels; this level only slices the
// packed per-channel buses onto prescaler_ch instances.
module prescaler_nch
  import prescaler_pkg::*;
#(
  parameter int NB_CH      = 4,
  parameter int NB_SEL     = 2,
  parameter int NB_COUNTER = 32,
  parameter int BASE_SHIFT = 10
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic [NB_CH-1:0]            i_enable,
  input  logic [NB_CH*NB_SEL-1:0]     i_sel,
  input  logic [NB_CH-1:0]            i_mode,
  input  logic [NB_CH-1:0]            i_start,
  output logic [NB_CH-1:0]            o_tick,
  output logic [NB_CH-1:0]            o_active,
  output logic [NB_CH*NB_COUNTER-1:0] o_count
);

  if (!params_legal(NB_SEL, NB_COUNTER, BASE_SHIFT)) begin : g_bad_params
    $error("prescaler_nch: NB_COUNTER-BASE_SHIFT-(2**NB_SEL-1) must be >= 1");
  end

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    prescaler_ch #(
      .NB_SEL     (NB_SEL),
      .NB_COUNTER (NB_COUNTER),
      .BASE_SHIFT (BASE_SHIFT)
    ) u_ch (
      .clock   (clock),
      .i_reset (i_reset),
      .enable  (i_enable[c]),
      .sel     (i_sel[c*NB_SEL +: NB_SEL]),
      .mode    (i_mode[c]),
      .start   (i_start[c]),
      .tick    (o_tick[c]),
      .active  (o_active[c]),
      .count   (o_count[c*NB_COUNTER +: NB_COUNTER])
    );
  end

endmodule

// File: tb/tb_prescaler_nch.sv
// Bench for prescaler_nch: tick cycles predicted at stimulus time into
// per-channel queues, popped and compared whenever a tick is observed.
module tb_prescaler_nch;

  localparam int NB_CH      = 4;
  localparam int NB_SEL     = 2;
  localparam int NB_COUNTER = 16;
  localparam int BASE_SHIFT = 10;

  logic                        clock = 1'b0;
  logic                        i_reset;
  logic [NB_CH-1:0]            i_enable;
  logic [NB_CH*NB_SEL-1:0]     i_sel;
  logic [NB_CH-1:0]            i_mode;
  logic [NB_CH-1:0]            i_start;
  logic [NB_CH-1:0]            o_tick;
  logic [NB_CH-1:0]            o_active;
  logic [NB_CH*NB_COUNTER-1:0] o_count;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc   = '0;
  logic [31:0] r, n0, m, p, q, s, u, target;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp_q3[$];

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;

  prescaler_nch #(
    .NB_CH      (NB_CH),
    .NB_SEL     (NB_SEL),
    .NB_COUNTER (NB_COUNTER),
    .BASE_SHIFT (BASE_SHIFT)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_sel    (i_sel),
    .i_mode   (i_mode),
    .i_start  (i_start),
    .o_tick   (o_tick),
    .o_active (o_active),
    .o_count  (o_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt(input int c);
    return o_count[c*NB_COUNTER +: NB_COUNTER];
  endfunction

  // scoreboard
  task automatic pop_expect(input int c, input logic [31:0] now);
    logic [31:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (c)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      2: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
      default: if (exp_q3.size() > 0) begin e = exp_q3.pop_front(); have = 1'b1; end
    endcase
    if (have) check($sformatf("ch%0d_tick_cycle", c), now, e);
    else      check($sformatf("ch%0d_tick_unexpected", c), now, 0);
  endtask

  always @(negedge clock)
    for (int c = 0; c < NB_CH; c++)
      if (o_tick[c] === 1'b1) pop_expect(c, cyc);

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input int c);
    i_start[c] = 1'b1;
    @(negedge clock);
    i_start[c] = 1'b0;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_enable = 4'b0001;
    i_mode   = 4'b0010;
    i_start  = 4'b0000;
    i_sel    = {2'd0, 2'd1, 2'd3, 2'd0};
    cycles(3);
    check("rst_tick", o_tick, 0);
    check("rst_active", o_active, 0);
    check("rst_count", o_count, 0);

    // release: ch0 periodic sel0 ticks every 64 cycles once armed
    i_reset = 1'b0;
    r = cyc;
    for (int j = 0; j < 12; j++) exp_q0.push_back(r + 32'd65 + 32'd64 * j);
    cycles(1);
    check("init_active", o_active, 4'b1101);
    check("init_count", o_count, 0);
    cycles($urandom_range(1, 8));
    check("ch0_phase", cnt(0), (cyc - r - 32'd1) % 32'd64);

    // ch2: freeze at 20 for 50 cycles, start ignored while disabled
    n0 = cyc;
    i_enable[2] = 1'b1;
    cycles(20);
    check("ch2_cnt20", cnt(2), 20);
    i_enable[2] = 1'b0;
    cycles(25);
    pulse_start(2);
    cycles(24);
    check("ch2_frozen", cnt(2), 20);
    check("ch2_active_held", o_active[2], 1);
    m = cyc;
    i_enable[2] = 1'b1;
    exp_q2.push_back(m + 32'd12);
    exp_q2.push_back(m + 32'd44);
    cycles(44);
    i_enable[2] = 1'b0;
    check("ch2_cnt_after_tick", cnt(2), 0);

    // ch3: speed change at count 40 restarts without a tick
    cycles($urandom_range(1, 8));
    p = cyc;
    i_enable[3] = 1'b1;
    cycles(40);
    check("ch3_cnt40", cnt(3), 40);
    i_sel[7:6] = 2'd2;
    cycles(1);
    check("ch3_sel_restart", cnt(3), 0);
    exp_q3.push_back(p + 32'd57);
    exp_q3.push_back(p + 32'd73);
    cycles(32);
    i_enable[3] = 1'b0;

    // ch2 mode switching
    i_mode[2] = 1'b1;
    cycles(1);
    check("ch2_to_oneshot_active", o_active[2], 0);
    check("ch2_to_oneshot_count", cnt(2), 0);
    i_mode[2] = 1'b0;
    cycles(1);
    check("ch2_to_periodic_active", o_active[2], 1);

    // ch1 one-shot sel3
    i_enable[1] = 1'b1;
    cycles($urandom_range(1, 8));
    check("ch1_idle_active", o_active[1], 0);
    q = cyc;
    pulse_start(1);
    check("ch1_armed", o_active[1], 1);
    check("ch1_start_count", cnt(1), 0);
    exp_q1.push_back(q + 32'd9);
    cycles(9);
    check("ch1_done_active", o_active[1], 0);
    check("ch1_done_count", cnt(1), 0);
    cycles(100);
    check("ch1_still_idle", o_active[1], 0);

    // ch1 retrigger at count 5
    s = cyc;
    pulse_start(1);
    cycles(5);
    check("ch1_cnt5", cnt(1), 5);
    pulse_start(1);
    check("ch1_retrig_count", cnt(1), 0);
    check("ch1_retrig_active", o_active[1], 1);
    exp_q1.push_back(s + 32'd15);
    cycles(10);
    check("ch1_retrig_done", o_active[1], 0);

    // let ch0's predicted ticks all occur
    target = r + 32'd65 + 32'd64 * 11 + 32'd1;
    for (int k = 0; k < 2000 && cyc < target; k++) @(negedge clock);
    check("ch0_pending", exp_q0.size(), 0);

    // reset mid one-shot at count 4: aborts with no tick
    u = cyc;
    pulse_start(1);
    cycles(4);
    check("ch1_cnt4", cnt(1), 4);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_tick", o_tick, 0);
    check("async_rst_active", o_active, 0);
    check("async_rst_count", o_count, 0);
    cycles(12);
    i_reset = 1'b0;
    cycles(3);

    check("ch1_pending", exp_q1.size(), 0);
    check("ch2_pending", exp_q2.size(), 0);
    check("ch3_pending", exp_q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
